// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / memory stage) in front of one single-port memory.
// Commands are latched at grant and held stable for the whole access.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IReqF,
  input  logic [ADDR_W-1:0] IAddrF,
  input  logic              DReqM,
  input  logic              DWeM,
  input  logic [ADDR_W-1:0] DAddrM,
  input  logic [DATA_W-1:0] DWDataM,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemReady,
  input  logic [DATA_W-1:0] MemRData,
  output logic [DATA_W-1:0] IRDataF,
  output logic [DATA_W-1:0] DRDataM,
  output logic              StallF,
  output logic              StallM
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] IBUSY = 3'd1;
  localparam logic [2:0] DBUSY = 3'd2;
  localparam logic [2:0] IDONE = 3'd3;
  localparam logic [2:0] DDONE = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              last_d;
  logic              cmd_we;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              grant_i;
  logic              grant_d;

  // Instruction wins a tie only when the previous grant went to data.
  assign grant_i = IReqF && (!DReqM || last_d);
  assign grant_d = DReqM && !grant_i;

  // Next state and command to be latched on leaving IDLE.
  always_comb begin
    state_nxt = state;
    we_nxt    = cmd_we;
    addr_nxt  = MemAddr;
    wdata_nxt = MemWData;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt = IBUSY;
          we_nxt    = 1'b0;
          addr_nxt  = IAddrF;
          wdata_nxt = '0;
        end else if (grant_d) begin
          state_nxt = DBUSY;
          we_nxt    = DWeM;
          addr_nxt  = DAddrM;
          wdata_nxt = DWDataM;
        end
      end
      IBUSY:   if (MemReady) state_nxt = IDONE;
      DBUSY:   if (MemReady) state_nxt = DDONE;
      IDONE:   state_nxt = IDLE;
      DDONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched command, registered memory strobes and read data.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      cmd_we   <= 1'b0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      IRDataF  <= '0;
      DRDataM  <= '0;
    end else begin
      state    <= state_nxt;
      cmd_we   <= we_nxt;
      MemAddr  <= addr_nxt;
      MemWData <= wdata_nxt;
      MemReq   <= (state_nxt == IBUSY) || (state_nxt == DBUSY);
      MemWe    <= (state_nxt == DBUSY) && we_nxt;
      if (state == IBUSY && MemReady) begin
        IRDataF <= MemRData;
        last_d  <= 1'b0;
      end
      if (state == DBUSY && MemReady) begin
        if (!cmd_we) DRDataM <= MemRData;
        last_d <= 1'b1;
      end
    end
  end

  assign StallF = IReqF && (state != IDONE);
  assign StallM = DReqM && (state != DDONE);

endmodule
